// File: rtl/text_script_sequencer.sv
// text_script_sequencer: runs draw/erase/wait/end scripts from an external ROM through a string-drawer handshake
//   clk, reset (async, active-low)
//   start, script_sel, abort, btn         : control from the game FSM
//   script_addr -> ROM, script_data <- ROM: {sel, pc} address, combinational read
//   str_id, x_off, y_off, pixel_color     : registered drawer arguments
//   draw_clear, draw_start <- draw_done   : drawer handshake
//   busy, done                            : run status
module text_script_sequencer #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_SCRIPTS = 4,
  parameter int COORD_W = 11,
  parameter int ID_W = 4,
  parameter int SETTLE_CYC = 6,
  parameter int ENTRY_W = 2 + 2 * COORD_W + ID_W,
  localparam int PCW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1,
  localparam int SW = NUM_SCRIPTS > 1 ? $clog2(NUM_SCRIPTS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [SW-1:0] script_sel,
  input  logic abort,
  input  logic btn,
  output logic [SW+PCW-1:0] script_addr,
  input  logic [ENTRY_W-1:0] script_data,
  output logic [ID_W-1:0] str_id,
  output logic [COORD_W-1:0] x_off,
  output logic [COORD_W-1:0] y_off,
  output logic pixel_color,
  output logic draw_clear,
  output logic draw_start,
  input  logic draw_done,
  output logic busy,
  output logic done
);
  localparam logic [1:0] OP_WAIT = 2'd2;
  localparam logic [1:0] OP_END = 2'd3;
  localparam logic [PCW-1:0] LAST_PC = PCW'(NUM_ENTRIES - 1);
  typedef enum logic [2:0] {IDLE, FETCH, CLEAR, SETTLE, DRAW, WAIT_BTN, NEXT, FINISHED} state_t;
  state_t state, state_d;
  logic [PCW-1:0] pc;
  logic [SW-1:0] sel_q;
  logic [7:0] cnt;
  logic armed;
  logic [1:0] op;
  assign op = script_data[ENTRY_W-1 -: 2];
  assign script_addr = {sel_q, pc};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (abort) state_d = IDLE;
    else
      case (state)
        IDLE: if (start) state_d = FETCH;
        FETCH: state_d = op == OP_WAIT ? WAIT_BTN : op == OP_END ? FINISHED : CLEAR;
        CLEAR: state_d = SETTLE;
        SETTLE: if (cnt == 8'(SETTLE_CYC - 1)) state_d = DRAW;
        // armed is low in the first DRAW cycle so a stale draw_done cannot finish the entry
        DRAW: if (draw_done && armed) state_d = NEXT;
        WAIT_BTN: if (btn) state_d = NEXT;
        NEXT: state_d = pc == LAST_PC ? FINISHED : FETCH;
        FINISHED: if (!start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    draw_clear = state == CLEAR;
    draw_start = state == DRAW;
    busy = state != IDLE && state != FINISHED;
    done = state == FINISHED;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= '0;
      sel_q <= '0;
      cnt <= '0;
      armed <= 1'b0;
      str_id <= '0;
      x_off <= '0;
      y_off <= '0;
      pixel_color <= 1'b1;
    end else begin
      armed <= state == DRAW;
      cnt <= state == SETTLE ? cnt + 8'd1 : 8'd0;
      if (abort) pc <= '0;
      else if (state == IDLE && start) begin
        sel_q <= script_sel;
        pc <= '0;
      end else if (state == NEXT && pc != LAST_PC) pc <= pc + PCW'(1);
      // only draw/erase entries update the drawer arguments
      if (state == FETCH && !op[1] && !abort) begin
        str_id <= script_data[ID_W-1:0];
        y_off <= script_data[COORD_W+ID_W-1 -: COORD_W];
        x_off <= script_data[2*COORD_W+ID_W-1 -: COORD_W];
        pixel_color <= !op[0];
      end
    end
endmodule

// File: tb/tb_text_script_sequencer.sv
// tb_text_script_sequencer: directed and randomized checks of text_script_sequencer against a time-in-entry model
module tb_text_script_sequencer;
  localparam int NE = 8, NS = 4, CW = 11, IDW = 4, S = 6, EW = 2 + 2 * CW + IDW, PCW = 3, SW = 2;
  logic clk = 0, reset = 1, start = 0, abort = 0, btn = 0, draw_done = 0;
  logic [SW-1:0] script_sel = '0;
  logic [SW+PCW-1:0] script_addr;
  logic [EW-1:0] script_data;
  logic [IDW-1:0] str_id;
  logic [CW-1:0] x_off, y_off;
  logic pixel_color, draw_clear, draw_start, busy, done;
  logic [EW-1:0] rom [NS*NE];
  assign script_data = rom[script_addr];
  always #5 clk = ~clk;

  text_script_sequencer #(.NUM_ENTRIES(NE), .NUM_SCRIPTS(NS), .COORD_W(CW), .ID_W(IDW), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .start(start), .script_sel(script_sel), .abort(abort), .btn(btn),
    .script_addr(script_addr), .script_data(script_data), .str_id(str_id), .x_off(x_off), .y_off(y_off),
    .pixel_color(pixel_color), .draw_clear(draw_clear), .draw_start(draw_start), .draw_done(draw_done),
    .busy(busy), .done(done));

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int op, input int x, input int y, input int id);
    return {op[1:0], x[CW-1:0], y[CW-1:0], id[IDW-1:0]};
  endfunction

  // model: mode 0 idle / 1 running / 2 finished; m_t counts cycles spent in the current entry
  // (0 = fetch, 1 = clear, 2..S+1 = settle, S+2.. = drawing); m_nx marks the one-cycle step to the next entry
  int m_mode, m_pc, m_sel, m_t, e_id, e_x, e_y, e_pix;
  bit m_nx;
  always @(posedge clk or negedge reset) begin
    logic [EW-1:0] e;
    int op;
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_sel = 0; m_t = 0; m_nx = 0;
      e_id = 0; e_x = 0; e_y = 0; e_pix = 1;
    end else if (abort) begin
      m_mode = 0; m_pc = 0; m_t = 0; m_nx = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_sel = int'(script_sel); m_pc = 0; m_t = 0; m_nx = 0; end
    end else if (m_mode == 2) begin
      if (!start) m_mode = 0;
    end else if (m_nx) begin
      m_nx = 0; m_t = 0;
      if (m_pc == NE - 1) m_mode = 2;
      else m_pc++;
    end else begin
      e = rom[m_sel * NE + m_pc];
      op = int'(e[EW-1 -: 2]);
      if (m_t == 0 && op < 2) begin
        e_id = int'(e[IDW-1:0]);
        e_y = int'(e[CW+IDW-1 -: CW]);
        e_x = int'(e[2*CW+IDW-1 -: CW]);
        e_pix = op == 0 ? 1 : 0;
      end
      if (op == 3) m_mode = 2;
      else if (op == 2 && m_t >= 1 && btn) m_nx = 1;
      else if (op < 2 && m_t >= S + 3 && draw_done) m_nx = 1;
      else m_t++;
    end
  end

  always @(negedge clk) begin
    int op;
    bit dr;
    op = int'(rom[m_sel * NE + m_pc][EW-1 -: 2]);
    dr = m_mode == 1 && !m_nx && op < 2;
    chk("busy", busy, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("draw_clear", draw_clear, dr && m_t == 1);
    chk("draw_start", draw_start, dr && m_t >= S + 2);
    chk("script_addr", script_addr, m_sel * NE + m_pc);
    chk("str_id", str_id, e_id);
    chk("x_off", x_off, e_x);
    chk("y_off", y_off, e_y);
    chk("pixel_color", pixel_color, e_pix);
  end

  // drawer emulation and event monitor
  typedef struct {int id; int x; int y; int pix;} draw_t;
  draw_t drawq[$];
  draw_t dq;
  int cyc = 0, ds_cnt = 0, dd_lat = 3, t_leave = 0, t_clr = 0, t_start = 0, clr_cnt = 0;
  bit dd_hold = 0, dd_rnd = 0, prev_ds = 0, prev_clr = 0, prev_busy = 0;
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (busy && !prev_busy) t_leave = cyc;
    if (draw_clear) begin
      clr_cnt++;
      if (!prev_clr) t_clr = cyc;
    end
    if (draw_start && !prev_ds) begin
      t_start = cyc;
      dq.id = int'(str_id); dq.x = int'(x_off); dq.y = int'(y_off); dq.pix = int'(pixel_color);
      drawq.push_back(dq);
    end
    ds_cnt = draw_start ? ds_cnt + 1 : 0;
    draw_done = dd_hold || (draw_start && ds_cnt > dd_lat) || (dd_rnd && $urandom_range(0, 2) == 0);
    prev_ds = draw_start; prev_clr = draw_clear; prev_busy = busy;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic wait_done(input int max, input string name);
    int k = 0;
    while (!done && k < max) begin tick(); k++; end
    chk(name, done, 1);
  endtask
  task automatic wait_draw(input int max, input string name);
    int k = 0;
    while (!draw_start && k < max) begin tick(); k++; end
    chk(name, draw_start, 1);
  endtask

  initial begin
    int eid[4] = '{1, 2, 2, 3};
    int ex[4] = '{220, 150, 150, 235};
    int ey[4] = '{10, 60, 60, 60};
    int ep[4] = '{1, 1, 0, 1};
    int k;
    for (int i = 0; i < NS * NE; i++) rom[i] = ent(3, 0, 0, 0);
    rom[0] = ent(0, 220, 10, 1); rom[1] = ent(0, 150, 60, 2); rom[2] = ent(2, 0, 0, 0);
    rom[3] = ent(1, 150, 60, 2); rom[4] = ent(0, 235, 60, 3);
    for (int i = 0; i < NE; i++) rom[NE + i] = ent(0, 10 * i + 3, 20 * i + 1, i + 1);
    rom[16] = ent(0, 7, 9, 5);
    rom[24] = ent(2, 0, 0, 0);
    #1 reset = 0;
    #2;
    chk("rst_str_id", str_id, 0); chk("rst_x", x_off, 0); chk("rst_y", y_off, 0);
    chk("rst_pix", pixel_color, 1); chk("rst_clear", draw_clear, 0); chk("rst_start", draw_start, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_addr", script_addr, 0);
    tick(2);
    reset = 1;
    tick(2);
    // script 0: three draws, a button wait and an erase
    dd_lat = 20; drawq.delete(); script_sel = 0; start = 1;
    tick(200);
    btn = 1;
    wait_done(600, "s0_done");
    btn = 0;
    chk("s0_draws", drawq.size(), 4);
    for (int i = 0; i < 4 && i < drawq.size(); i++) begin
      chk("s0_id", drawq[i].id, eid[i]); chk("s0_x", drawq[i].x, ex[i]);
      chk("s0_y", drawq[i].y, ey[i]); chk("s0_pix", drawq[i].pix, ep[i]);
    end
    tick(3);
    chk("s0_hold_done", done, 1);
    start = 0;
    tick();
    chk("s0_idle", busy | done, 0);
    // latency of a single draw
    dd_lat = 2; clr_cnt = 0; script_sel = 2; start = 1;
    wait_done(200, "lat_done");
    start = 0;
    tick();
    chk("lat_start", t_start - t_leave, 8);
    chk("lat_clear", t_start - t_clr, 7);
    chk("lat_clr_len", clr_cnt, 1);
    // eight draws without END, done already high in first DRAW cycle
    dd_lat = 0; drawq.delete(); script_sel = 1; start = 1;
    wait_done(1000, "noend_done");
    chk("noend_draws", drawq.size(), 8);
    chk("noend_pc", script_addr, 15);
    start = 0;
    tick();
    // abort in SETTLE of entry 1
    dd_lat = 3; drawq.delete(); clr_cnt = 0; start = 1;
    tick();
    start = 0;
    k = 0;
    while (clr_cnt < 2 && k < 200) begin tick(); k++; end
    chk("ab1_reach", clr_cnt, 2);
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("ab1_busy", busy, 0); chk("ab1_start", draw_start, 0); chk("ab1_pc", script_addr[PCW-1:0], 0);
    tick(10);
    chk("ab1_quiet", drawq.size(), 1);
    // abort coinciding with a held draw_done
    dd_hold = 1; start = 1;
    tick();
    start = 0;
    wait_draw(100, "ab2_reach");
    tick();
    chk("ab2_first_ignored", draw_start, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("ab2_busy", busy, 0); chk("ab2_start", draw_start, 0); chk("ab2_pc", script_addr[PCW-1:0], 0);
    dd_hold = 0;
    tick(3);
    // button already high before WAIT_BTN
    btn = 1; script_sel = 3; start = 1;
    tick(4);
    chk("btn_not_yet", done, 0);
    tick();
    chk("btn_fast", done, 1);
    start = 0; btn = 0;
    tick(2);
    // asynchronous reset mid-draw, then restart on script 2
    dd_lat = 50; script_sel = 1; start = 1;
    wait_draw(100, "rst_reach");
    start = 1; script_sel = 2;
    #1 reset = 0;
    #1;
    chk("arst_start", draw_start, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    #2 reset = 1;
    tick();
    chk("arst_addr", script_addr, 16);
    dd_lat = 1;
    wait_done(100, "arst_done2");
    start = 0;
    tick(2);
    // randomized runs
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NE; i++) begin
        int q = $urandom_range(0, 7);
        rom[3 * NE + i] = ent(q < 4 ? 0 : q < 6 ? 1 : q == 6 ? 2 : 3,
                              $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 15));
      end
      dd_lat = $urandom_range(0, 4); dd_rnd = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 300; c++) begin
        start = ($urandom_range(0, 15) != 0);
        abort = ($urandom_range(0, 299) == 0);
        btn = ($urandom_range(0, 5) == 0);
        script_sel = 2'($urandom_range(0, 3));
        tick();
      end
      start = 0; abort = 1;
      tick();
      abort = 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/text_script_sequencer.md
Name: text_script_sequencer

Overview:
- Parametrised, script-driven successor to the fixed startup text sequencer.
- Steps through an external script ROM of up to NUM_SCRIPTS scripts × NUM_ENTRIES entries.
- Each entry is one command: draw string, erase string, wait for button, or end.
- Drives a downstream string-drawer over a clear/start/done handshake; sits between game control FSM and the string-to-screen block.

Parameters:
- NUM_ENTRIES, 8, entries per script; pc width PCW = $clog2(NUM_ENTRIES).
- NUM_SCRIPTS, 4, selectable scripts; SW = $clog2(NUM_SCRIPTS), minimum 1.
- COORD_W, 11, x/y offset width.
- ID_W, 4, string-ROM index width.
- SETTLE_CYC, 6, cycles between drawer clear and draw_start assertion; legal range 2..255.
- ENTRY_W, 2+2*COORD_W+ID_W, script word width; derived, do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; run request, sampled in IDLE and FINISHED.
- script_sel  in  SW  script to run; latched on leaving IDLE.
- abort  in  1  synchronous; forces IDLE from any state.
- btn  in  1  play button, already synchronised, level-sensitive.
- script_addr  out  SW+PCW  {sel_q, pc} to script ROM; combinational ROM read, same cycle.
- script_data  in  ENTRY_W  entry fields: [op 2][x_off COORD_W][y_off COORD_W][str_id ID_W]; op 0=DRAW, 1=ERASE, 2=WAIT_BTN, 3=END.
- str_id  out  ID_W  registered string index to drawer.
- x_off, y_off  out  COORD_W each  registered drawer offsets.
- pixel_color  out  1  1 for DRAW, 0 for ERASE; registered.
- draw_clear  out  1  one-cycle drawer reset pulse.
- draw_start  out  1  drawer start, held until draw_done.
- draw_done  in  1  drawer completion.
- busy  out  1  high in every state except IDLE and FINISHED.
- done  out  1  high in FINISHED.

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=0, sel_q=0, settle counter=0; str_id=0, x_off=0, y_off=0, pixel_color=1, draw_clear=0, draw_start=0, busy=0, done=0.
- States: IDLE, FETCH, CLEAR, SETTLE, DRAW, WAIT_BTN, NEXT, FINISHED.
- IDLE: when start=1, latch sel_q<=script_sel, pc<=0, go FETCH.
- FETCH (1 cycle): register script_data fields.
  - DRAW/ERASE -> CLEAR.
  - WAIT_BTN -> WAIT_BTN.
  - END -> FINISHED.
- CLEAR (1 cycle): draw_clear=1, settle counter<=0, -> SETTLE.
- SETTLE: counter increments each cycle; when counter==SETTLE_CYC-1, -> DRAW.
- DRAW: draw_start=1. A draw_done already high on DRAW entry is ignored for one cycle, so stale done cannot complete. On draw_done=1 in a later DRAW cycle, draw_start drops next cycle, -> NEXT.
- WAIT_BTN: stays until btn=1; btn already high on entry passes after 1 cycle; -> NEXT.
- NEXT (1 cycle):
  - If pc==NUM_ENTRIES-1 -> FINISHED (implicit END, no wrap).
  - Else pc<=pc+1, -> FETCH.
- FINISHED: done=1; stays while start=1; start=0 -> IDLE next cycle.
- abort=1 in any state: next cycle IDLE, draw_start=0, draw_clear=0, pc=0. Abort has priority over all other transitions, including a draw_done arriving the same cycle.
- Latency: DRAW entry reaches draw_start=1 after 1 (FETCH) + 1 (CLEAR) + SETTLE_CYC cycles.
- Entry done to next FETCH: 1 cycle (NEXT).
- script_addr changes only in NEXT/IDLE; stable throughout each entry's execution.
- script_sel changes while busy have no effect.
- Reset asserted mid-draw: all outputs return to reset values immediately (async).

Test Plan:
- Script 0 = {DRAW id=1 x=220 y=10, DRAW id=2 x=150 y=60, WAIT_BTN, ERASE id=2 x=150 y=60, DRAW id=3 x=235 y=60, END}; start=1, drawer done 20 cycles after start, btn at cycle 200 -> four draw_start pulses with matching id/x/y, pixel_color 1,1,0,1; done=1 after END; start=0 -> IDLE.
- SETTLE_CYC=6, single DRAW -> draw_start rises exactly 8 cycles after leaving IDLE; draw_clear high exactly 1 cycle, 7 cycles before draw_start.
- Script with no END, NUM_ENTRIES=8, all DRAW -> 8 draws, pc never wraps, FINISHED after the entry at pc=7.
- abort pulsed during SETTLE of entry 1, and again coinciding with draw_done -> IDLE next cycle, draw_start=0, pc=0, no further drawer activity.
- btn held high before WAIT_BTN -> passes in 1 cycle; draw_done held high across DRAW entry -> ignored for first DRAW cycle.
- reset driven low asynchronously mid-DRAW (not on a clock edge) -> draw_start, busy, and done go 0 immediately; after reset release with start=1 and script_sel=2 -> script_addr={2,0}.
